// File: rtl/gain_divider_if.sv
// Handshake and operand/result bundle for gain_divider.
// The master drives the request and operands, and the slave returns the status and the results.
interface gain_divider_if #(
    parameter int unsigned WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/gain_divider.sv
// Restoring shift-subtract unsigned divider that produces one quotient bit per enabled clock.
// Its results are registered and held until the next accepted operation.
module gain_divider #(
    parameter int unsigned WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    gain_divider_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] div_reg;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    // One restoring step: the dividend bits shift out of the top of shift_reg while quotient bits enter at the bottom.
    always_comb begin
        shifted   = {part_rem[WIDTH-1:0], shift_reg[WIDTH-1]};
        fits      = (shifted >= {1'b0, div_reg});
        rem_next  = fits ? (shifted - {1'b0, div_reg}) : shifted;
        quo_next  = {shift_reg[WIDTH-2:0], fits};
        last_step = (count == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            part_rem        <= '0;
            shift_reg       <= '0;
            div_reg         <= '0;
            count           <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (ena) begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            part_rem  <= '0;
                            shift_reg <= bus.dividend;
                            div_reg   <= bus.divisor;
                            count     <= '0;
                            bus.busy  <= 1'b1;
                            state     <= RUN;
                        end else begin
                            // A zero divisor finishes immediately with a saturated quotient.
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    part_rem  <= rem_next;
                    shift_reg <= quo_next;
                    count     <= count + CNT_W'(1);
                    if (last_step) begin
                        bus.quotient    <= quo_next;
                        bus.remainder   <= rem_next[WIDTH-1:0];
                        bus.div_by_zero <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gain_divider.sv
// Self-checking bench for gain_divider.
// It applies a table of directed vectors, random operands checked against an arithmetic model, and hand-written sequences for freeze, overlap and reset.
module tb_gain_divider;
    localparam int unsigned W = 6;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic ena;

    gain_divider_if #(.WIDTH(W)) bus ();

    gain_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one operation and checks the latency, the busy profile, the results and the one-cycle done pulse.
    task automatic run_op(input int a, input int b, input int exp_q, input int exp_r,
                          input int exp_dbz, input string tag);
        int lat;
        int busy_cyc;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 0;
        busy_cyc  = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, (exp_dbz != 0) ? 0 : int'(W));
        check({tag, " busy cycles"}, busy_cyc, lat);
        check({tag, " busy at done"}, int'(bus.busy), 0);
        check({tag, " quotient"}, int'(bus.quotient), exp_q);
        check({tag, " remainder"}, int'(bus.remainder), exp_r);
        check({tag, " div_by_zero"}, int'(bus.div_by_zero), exp_dbz);
        @(negedge clk);
        check({tag, " done cleared"}, int'(bus.done), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        int   k;
        int   done_seen;

        vecs[0] = '{45, 7, 6, 3, 0};
        vecs[1] = '{63, 1, 63, 0, 0};
        vecs[2] = '{5, 9, 0, 5, 0};
        vecs[3] = '{63, 63, 1, 0, 0};
        vecs[4] = '{20, 0, 63, 20, 1};
        vecs[5] = '{20, 4, 5, 0, 0};

        rst = 1'b1; ena = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset quotient", int'(bus.quotient), 0);
        check("reset remainder", int'(bus.remainder), 0);
        check("reset div_by_zero", int'(bus.div_by_zero), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
                   $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b));

        // The random operands draw divisor 0 now and then, which exercises the saturating path.
        for (int i = 0; i < 25; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, MAXV));
            b = int'($urandom_range(0, 9)) == 0 ? 0 : int'($urandom_range(1, MAXV));
            if (b == 0) run_op(a, b, MAXV, a, 1, $sformatf("rand%0d %0d/0", i, a));
            else        run_op(a, b, a / b, a % b, 0, $sformatf("rand%0d %0d/%0d", i, a, b));
        end

        // Freeze for three cycles in the middle of a run. The previous result (5 r 0) must hold.
        run_op(20, 4, 5, 0, 0, "pre-freeze 20/4");
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = W'(45); bus.divisor = W'(7);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            check($sformatf("freeze hold q @%0d", lat), int'(bus.quotient), 5);
            check($sformatf("freeze busy @%0d", lat), int'(bus.busy), 1);
            ena = !(lat >= 2 && lat < 5);
            @(negedge clk);
            lat++;
        end
        check("freeze latency", lat, 9);
        check("freeze quotient", int'(bus.quotient), 6);
        check("freeze remainder", int'(bus.remainder), 3);
        ena = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("done held while ena low", int'(bus.done), 1);
        end
        ena = 1'b1;
        @(negedge clk);
        check("done cleared after ena", int'(bus.done), 0);

        // Hold start high throughout and change the operands after the accept. The run in flight must ignore them, and the held start is accepted on the done cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = W'(45); bus.divisor = W'(7);
        @(posedge clk);
        @(negedge clk);
        bus.dividend = W'(10); bus.divisor = W'(2);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("overlap first latency", lat, 6);
        check("overlap first quotient", int'(bus.quotient), 6);
        check("overlap first remainder", int'(bus.remainder), 3);
        @(negedge clk);
        bus.start = 1'b0;
        check("back-to-back accepted busy", int'(bus.busy), 1);
        k = 1;
        while (bus.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("back-to-back gap", k, 7);
        check("back-to-back quotient", int'(bus.quotient), 5);
        check("back-to-back remainder", int'(bus.remainder), 0);

        // Reset in the middle of a run aborts it without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = W'(45); bus.divisor = W'(7);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        check("abort quotient", int'(bus.quotient), 0);
        check("abort remainder", int'(bus.remainder), 0);
        check("abort div_by_zero", int'(bus.div_by_zero), 0);
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        check("abort no done/busy afterwards", done_seen, 0);

        // With start and rst high at the same edge, the reset wins and the start is lost.
        bus.start = 1'b1; bus.dividend = W'(45); bus.divisor = W'(7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("start+rst busy", int'(bus.busy), 0);
        @(negedge clk);
        check("start+rst busy later", int'(bus.busy), 0);

        run_op(45, 7, 6, 3, 0, "post-reset 45/7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gain_divider.md
# gain_divider

Sequential unsigned divider that computes quotient and remainder by restoring shift-subtract, one quotient bit per enabled clock. It is the inverse of the controller's repeated-addition gain multiplier. It scales a controller term down by a divisor (e.g. normalising a gain-weighted error back to actuator range) and sits between the P/I/D contribution stage and the output summation. Operation uses a start/busy/done handshake; results are registered and held until the next accepted operation.

## Interface
- WIDTH, 6, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- ena  input  1  global enable; when low, all state and outputs freeze (rst still acts)
- start  input  1  request; sampled only when idle and ena=1
- dividend  input  WIDTH  unsigned numerator, captured on accepted start
- divisor  input  WIDTH  unsigned denominator, captured on accepted start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse: results just updated
- quotient  output  WIDTH  floor(dividend/divisor)
- remainder  output  WIDTH  dividend mod divisor
- div_by_zero  output  1  set when the last accepted operation had divisor=0

## Operation
- Reset (rst=1 at an edge): busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE, all working registers cleared. rst overrides ena and any in-flight operation.
- States: IDLE, RUN.
- IDLE, ena=1, start=1, divisor≠0:
  - Capture the operands into working registers: partial remainder (WIDTH+1 bits)=0, shift register=dividend, step counter=0.
  - Go to RUN; busy=1.
- IDLE, ena=1, start=1, divisor=0:
  - Stay IDLE.
  - quotient=all ones, remainder=dividend, div_by_zero=1, done=1 for one cycle.
- RUN, ena=1, each edge performs one step:
  - Shift the MSB of the shift register into the partial remainder.
  - If the partial remainder ≥ divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - Increment the counter.
- Completion: on the edge where the counter reaches WIDTH:
  - quotient and remainder load the final values; div_by_zero=0.
  - done=1 for one cycle; busy=0; return to IDLE.
- quotient, remainder and div_by_zero change only at completion, on a divide-by-zero accept, or on reset. Otherwise they hold.
- start while busy: ignored, with no effect on the operands or the result.
- ena=0: no state advance. done, if currently high, stays high until the next ena=1 edge clears it. Operand inputs are not re-sampled.
- Arithmetic: unsigned only. The remainder is always < divisor. The partial remainder needs WIDTH+1 bits so that no compare overflows.

## Timing
- Accepted start at edge N (divisor≠0, ena continuously high):
  - busy=1 after edge N.
  - Results and done=1 after edge N+WIDTH, with busy=0 at the same time.
  - done clears after edge N+WIDTH+1.
- Each ena=0 cycle during RUN delays completion by exactly one cycle.
- The earliest next accept is edge N+WIDTH+1, which is the cycle where done=1. Sustained throughput is one result per WIDTH+1 cycles.
- Divide-by-zero accept at edge N: results and done=1 after edge N, and busy never rises.
- rst during RUN: after that edge, busy=0 and all outputs are 0. No done pulse is produced, and the aborted operation is discarded.
- start and rst high at the same edge: rst wins and the start is lost.

## Test plan
- dividend=45, divisor=7, start at edge N: busy high for cycles N+1..N+6; after edge N+6, quotient=6, remainder=3, done=1 for one cycle, div_by_zero=0.
- Boundaries (WIDTH=6):
  - 63/1 gives quotient 63, remainder 0.
  - 5/9 gives quotient 0, remainder 5.
  - 63/63 gives quotient 1, remainder 0.
  - Each completes after 6 cycles.
- dividend=20, divisor=0: after edge N, quotient=63, remainder=20, div_by_zero=1, done=1, busy stays 0. A following 20/4 run clears div_by_zero and gives quotient 5, remainder 0.
- ena low for 3 cycles mid-RUN on 45/7: done arrives at N+9. No output changes while frozen.
- Pulse start with 10/2 during RUN of 45/7: the result is still 6 r 3. Back-to-back start held at the done cycle is accepted, and the second result appears 7 cycles after the first.
- rst asserted at edge N+3 of a 45/7 run: all outputs 0 and busy=0 after that edge, and no done pulse follows.
